// File: rtl/universal_shift_reg_if.sv
// Bus bundle for universal_shift_reg: control and data in, register state and
// serial taps out. The master drives the controls and the slave is the register.
interface universal_shift_reg_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             en;
    logic [2:0]       mode;
    logic [WIDTH-1:0] din;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] dout;
    logic             sout_l;
    logic             sout_r;
    logic [CNT_W-1:0] shift_cnt;
    logic             word_done;

    modport master (
        output en, mode, din, sin_r, sin_l,
        input  dout, sout_l, sout_r, shift_cnt, word_done
    );

    modport slave (
        input  en, mode, din, sin_r, sin_l,
        output dout, sout_l, sout_r, shift_cnt, word_done
    );
endinterface

// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: load, logical shift, rotate, clear,
// and a saturating shift counter that flags a completed word.
module universal_shift_reg #(
    parameter  int WIDTH = 4,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    universal_shift_reg_if.slave  bus
);
    localparam logic [2:0] MODE_HOLD  = 3'b000;
    localparam logic [2:0] MODE_LOAD  = 3'b001;
    localparam logic [2:0] MODE_SHL   = 3'b010;
    localparam logic [2:0] MODE_SHR   = 3'b011;
    localparam logic [2:0] MODE_ROTL  = 3'b100;
    localparam logic [2:0] MODE_ROTR  = 3'b101;
    localparam logic [2:0] MODE_CLEAR = 3'b110;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [WIDTH-1:0] dout_q;
    logic [WIDTH-1:0] dout_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             shift_s;

    // Next-state data path and counter; reserved mode falls through to hold.
    always_comb begin
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        shift_s = 1'b0;
        if (bus.en) begin
            case (bus.mode)
                MODE_HOLD: begin
                    dout_d = dout_q;
                end
                MODE_LOAD: begin
                    dout_d = bus.din;
                    cnt_d  = {CNT_W{1'b0}};
                end
                MODE_SHL: begin
                    dout_d  = {dout_q[WIDTH-2:0], bus.sin_r};
                    shift_s = 1'b1;
                end
                MODE_SHR: begin
                    dout_d  = {bus.sin_l, dout_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_ROTL: begin
                    dout_d  = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
                    shift_s = 1'b1;
                end
                MODE_ROTR: begin
                    dout_d  = {dout_q[0], dout_q[WIDTH-1:1]};
                    shift_s = 1'b1;
                end
                MODE_CLEAR: begin
                    dout_d = {WIDTH{1'b0}};
                    cnt_d  = {CNT_W{1'b0}};
                end
                default: begin
                    dout_d = dout_q;
                end
            endcase
        end else begin
            dout_d = dout_q;
        end

        // Counter saturates so word_done stays up until the next load/clear.
        if (shift_s && (cnt_q != CNT_FULL)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= {WIDTH{1'b0}};
            cnt_q  <= {CNT_W{1'b0}};
        end else begin
            dout_q <= dout_d;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.dout      = dout_q;
    assign bus.sout_l    = dout_q[WIDTH-1];
    assign bus.sout_r    = dout_q[0];
    assign bus.shift_cnt = cnt_q;
    assign bus.word_done = (cnt_q == CNT_FULL);
endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the 4-bit parallel-in/parallel-out register.
- Adds enable, parallel load, logical shift left and right with serial inputs, rotate left and right, synchronous clear, and a shift counter with a word-complete flag.
- Used for serial-to-parallel and parallel-to-serial conversion, and as a general datapath staging register.

Parameters:
- WIDTH, 4, data width in bits. Must be 2 or more.
- CNT_W, $clog2(WIDTH+1), shift counter width. Derived; do not override.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous reset, active-high.
- en  input  1  operation enable. When 0, all state holds regardless of mode.
- mode  input  3  operation select; encoding under Behaviour.
- din  input  WIDTH  parallel load data.
- sin_r  input  1  serial bit entering the LSB on shift left.
- sin_l  input  1  serial bit entering the MSB on shift right.
- dout  output  WIDTH  register contents.
- sout_l  output  1  dout[WIDTH-1]; combinational from the register.
- sout_r  output  1  dout[0]; combinational from the register.
- shift_cnt  output  CNT_W  number of shift/rotate operations since the last load, clear or reset. Saturates at WIDTH.
- word_done  output  1  high while shift_cnt == WIDTH.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- All state updates on the rising edge of clk. Latency is one cycle from inputs to dout.
- Priority: rst, then en, then mode.
- Reset values: dout=0, shift_cnt=0, word_done=0, sout_l=0, sout_r=0. rst overrides en and any mode, and aborts an in-progress word immediately.
- Mode encoding, applied when en=1:
  - 000 HOLD: no change.
  - 001 LOAD: dout<=din; shift_cnt<=0.
  - 010 SHL: dout<={dout[WIDTH-2:0], sin_r}.
  - 011 SHR: dout<={sin_l, dout[WIDTH-1:1]}.
  - 100 ROTL: dout<={dout[WIDTH-2:0], dout[WIDTH-1]}.
  - 101 ROTR: dout<={dout[0], dout[WIDTH-1:1]}.
  - 110 CLEAR: dout<=0; shift_cnt<=0.
  - 111: reserved; behaves as HOLD.
- Shift counter:
  - Increments by 1 on each SHL/SHR/ROTL/ROTR when en=1.
  - Saturates at WIDTH; it does not wrap. Further shifts still move data; shift_cnt stays at WIDTH.
  - HOLD, reserved mode and en=0 leave shift_cnt unchanged.
- word_done is derived directly from the shift_cnt register, with no extra stage. It rises in the cycle after the WIDTH-th shift and stays high until LOAD, CLEAR or rst.
- LOAD and a shift cannot occur together, since mode is a single field. The change of mode takes effect at the next edge.
- X on mode while en=1 is illegal. The bench flags it.

Test Plan:
- Reset (WIDTH=4): drive rst=1, en=1, mode=LOAD, din=1010 for 1 cycle -> dout=0000, shift_cnt=0, word_done=0. Release rst -> next edge dout=1010.
- Load/hold: LOAD din=1010, then HOLD 3 cycles, then en=0 with mode=SHL 2 cycles -> dout stays 1010 and shift_cnt=0 throughout.
- Shift left: from 1010, SHL with sin_r=1 for 5 cycles:
  - dout sequence 0101, 1011, 0111, 1111, 1111.
  - shift_cnt sequence 1, 2, 3, 4, 4.
  - word_done goes high after the 4th edge and stays high.
  - sout_l follows dout[3].
- Shift right: LOAD 1100, SHR with sin_l=0 for 3 cycles -> dout 0110, 0011, 0001; sout_r sequence 0, 1, 1.
  - Then LOAD 0110 -> shift_cnt=0 and word_done=0 next edge.
- Rotate: LOAD 1001.
  - ROTL ×4 -> 0011, 0110, 1100, 1001, with word_done=1 after the 4th.
  - Then LOAD 1001 and ROTR ×1 -> 1100.
- Mid-operation reset and clear: LOAD 1111, SHL twice, then rst=1 for 1 cycle -> dout=0000, shift_cnt=0.
  - Separately, LOAD 0110, SHL once, then CLEAR -> dout=0000, shift_cnt=0.
  - Mode 111 after LOAD 0101 -> dout holds 0101.
